// File: rtl/mem_wb_skid_if.sv
// MEM->WB handshake bundle: MEM side drives the in_* payload, WB side sees
// the out_* head entry. The slave modport belongs to the pipeline register.
interface mem_wb_skid_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  regWrite_in;
  logic                  memtoReg_in;
  logic [REG_ADDR_W-1:0] write_reg_in;
  logic [DATA_W-1:0]     mem_data_in;
  logic [DATA_W-1:0]     alu_result_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  regWrite_out;
  logic                  memtoReg_out;
  logic [REG_ADDR_W-1:0] write_reg_out;
  logic [DATA_W-1:0]     mem_data_out;
  logic [DATA_W-1:0]     alu_result_out;
  logic [DATA_W-1:0]     wb_data_out;

  modport slave (
    input  in_valid, regWrite_in, memtoReg_in, write_reg_in, mem_data_in, alu_result_in,
    input  out_ready,
    output in_ready, out_valid, regWrite_out, memtoReg_out, write_reg_out,
    output mem_data_out, alu_result_out, wb_data_out
  );

  modport master (
    output in_valid, regWrite_in, memtoReg_in, write_reg_in, mem_data_in, alu_result_in,
    output out_ready,
    input  in_ready, out_valid, regWrite_out, memtoReg_out, write_reg_out,
    input  mem_data_out, alu_result_out, wb_data_out
  );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer (main + skid).
// Main drives the WB outputs; skid catches one instruction while WB stalls.
// Optional feature macro: MEM_WB_ZERO_REG_SQUASH_EN -- when defined, an
// entry targeting register 0 is stored with regWrite cleared.
module mem_wb_skid_reg #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  mem_wb_skid_if.slave bus,
  output logic [15:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic                  rw;
    logic                  mt;
    logic [REG_ADDR_W-1:0] wr;
    logic [DATA_W-1:0]     md;
    logic [DATA_W-1:0]     alu;
  } ent_t;

  state_t      state_q, state_d;
  ent_t        main_q, main_d;
  ent_t        skid_q, skid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  ent_t        in_ent;
  logic        push, pop;

  // Valid bits are implied by the state: main valid in ONE/TWO, skid in TWO.
  assign bus.in_ready  = en & (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);

  assign push = bus.in_valid & bus.in_ready & en & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & en & ~flush;

  // Pack the incoming instruction, optionally squashing writes to r0.
  always_comb begin
    in_ent.mt  = bus.memtoReg_in;
    in_ent.wr  = bus.write_reg_in;
    in_ent.md  = bus.mem_data_in;
    in_ent.alu = bus.alu_result_in;
`ifdef MEM_WB_ZERO_REG_SQUASH_EN
    in_ent.rw  = bus.regWrite_in & (bus.write_reg_in != '0);
`else
    in_ent.rw  = bus.regWrite_in;
`endif
  end

  // Next-state and entry load/shift; flush wins, en=0 freezes everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (en) begin
      unique case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_ent;
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_ent;
          end else if (push) begin
            state_d = TWO;
            skid_d  = in_ent;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where WB holds off a valid head while enabled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.out_valid && !bus.out_ready && en && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State, entries and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Data may be stale after a flush, so regWrite is masked by out_valid.
  assign bus.regWrite_out   = main_q.rw & bus.out_valid;
  assign bus.memtoReg_out   = main_q.mt;
  assign bus.write_reg_out  = main_q.wr;
  assign bus.mem_data_out   = main_q.md;
  assign bus.alu_result_out = main_q.alu;
  assign bus.wb_data_out    = main_q.mt ? main_q.md : main_q.alu;
  assign stall_cnt          = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Randomized + directed bench for mem_wb_skid_reg against a queue model.
module tb_mem_wb_skid_reg;
  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [15:0] stall_cnt;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    bit        rw;
    bit        mt;
    bit [2:0]  wr;
    bit [15:0] md;
    bit [15:0] alu;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cnt = 0;

  mem_wb_skid_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

  mem_wb_skid_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output with the model, then advance the model on the edge.
  task automatic step();
    bit   ov, ir, po, pu;
    ent_t e;
    #2;
    ov = (mq.size() > 0);
    ir = en && (mq.size() < 2);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ov});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ir});
    chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    if (ov) begin
      e = mq[0];
      chk("regWrite", {31'd0, bus.regWrite_out}, {31'd0, e.rw});
      chk("memtoReg", {31'd0, bus.memtoReg_out}, {31'd0, e.mt});
      chk("write_reg", {29'd0, bus.write_reg_out}, {29'd0, e.wr});
      chk("mem_data", {16'd0, bus.mem_data_out}, {16'd0, e.md});
      chk("alu_result", {16'd0, bus.alu_result_out}, {16'd0, e.alu});
      chk("wb_data", {16'd0, bus.wb_data_out}, {16'd0, e.mt ? e.md : e.alu});
    end else begin
      chk("regWrite_idle", {31'd0, bus.regWrite_out}, 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (en && ov && !bus.out_ready && m_cnt < 32'hFFFF) m_cnt++;
      if (flush) mq.delete();
      else if (en) begin
        po = ov && bus.out_ready;
        pu = bus.in_valid && ir;
        if (po) void'(mq.pop_front());
        if (pu) begin
          e.rw  = bus.regWrite_in;
`ifdef MEM_WB_ZERO_REG_SQUASH_EN
          if (bus.write_reg_in == 3'd0) e.rw = 1'b0;
`endif
          e.mt  = bus.memtoReg_in;
          e.wr  = bus.write_reg_in;
          e.md  = bus.mem_data_in;
          e.alu = bus.alu_result_in;
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit mt, input bit [2:0] wr,
                       input bit [15:0] md, input bit [15:0] alu);
    bus.in_valid = v; bus.regWrite_in = rw; bus.memtoReg_in = mt;
    bus.write_reg_in = wr; bus.mem_data_in = md; bus.alu_result_in = alu;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    rst = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_wr", {29'd0, bus.write_reg_out}, 32'd0);
    chk("rst_md", {16'd0, bus.mem_data_out}, 32'd0);
    chk("rst_alu", {16'd0, bus.alu_result_out}, 32'd0);
    chk("rst_wb", {16'd0, bus.wb_data_out}, 32'd0);
    chk("rst_mt", {31'd0, bus.memtoReg_out}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 3'd1, 16'h0, 16'h0011 + 16'(i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Back-pressure: A then B with WB stalled, then drain
    bus.out_ready = 1'b0;
    drive(1, 1, 0, 3'd2, 16'h0, 16'h1234); step();
    drive(1, 1, 0, 3'd3, 16'h0, 16'h5678); step();
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #2;
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head", {16'd0, bus.alu_result_out}, 32'h1234);
    repeat (3) step();
    chk("bp_cnt", {16'd0, stall_cnt}, 32'd1);

    // Stall in TWO
    bus.out_ready = 1'b0;
    drive(1, 1, 1, 3'd4, 16'hAAAA, 16'h0); step();
    drive(1, 1, 1, 3'd5, 16'hBBBB, 16'h0); step();
    drive(1, 1, 0, 3'd6, 16'h0, 16'h0CCC);
    en = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step();
    en = 1'b1;

    // Flush with a simultaneous input
    flush = 1'b1; step();
    flush = 1'b0; drive(0, 0, 0, 0, 0, 0);
    step();

    // memtoReg mux, then r0 write
    drive(1, 1, 1, 3'd7, 16'hBEEF, 16'h0001); step();
    drive(1, 1, 0, 3'd7, 16'hBEEF, 16'h0001); step();
    drive(1, 1, 0, 3'd0, 16'h0, 16'h0042); step();
    drive(0, 0, 0, 0, 0, 0);
    #2;
`ifdef MEM_WB_ZERO_REG_SQUASH_EN
    chk("r0_squash", {31'd0, bus.regWrite_out}, 32'd0);
`else
    chk("r0_keep", {31'd0, bus.regWrite_out}, 32'd1);
`endif
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      bus.out_ready = $urandom_range(0, 1);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
